seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
- Scan and brightness controller for the multiplexed 7-segment display on the dice board.
- Time-multiplexes NDIG BCD digits onto one shared segment decoder and drives one active-high common-enable per digit.
- Applies PWM brightness, leading-zero blanking, blank-while-held, and an inactivity timeout.
- Sits between the dice digit registers and the seg7 decoder and polarity-inversion output stage.

Parameters:
- NDIG, 2, number of digits scanned, 2..4.
- SLOT_W, 4, clocks per digit slot = 2^SLOT_W; also the width of brightness.
- TMO_W, 8, timeout counter width.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset. Synchronous, active-low.
- tick  input  1  single-cycle timeout pulse, nominally 32 Hz.
- digits  input  4*NDIG  BCD digits; [3:0] is the least significant digit.
- activity  input  1  pulse; reloads the timeout.
- hold  input  1  level; blanks all commons while high (button held).
- blank_lz  input  1  enables leading-zero suppression.
- brightness  input  SLOT_W  on-clocks per slot; 0 = dark.
- seg_digit  output  4  BCD value for the decoder.
- com  output  NDIG  one-hot-or-zero common enables, active high.
- display_on  output  1  timeout counter non-zero.

Behaviour:
- Reset (rst_n low at posedge clk) sets all state and outputs to 0: slot_cnt, idx, snap, tmo, seg_digit, com, display_on.
- slot_cnt:
  - SLOT_W-bit free-running counter, +1 every clock, wraps naturally.
  - When slot_cnt is all ones, idx advances: idx = (idx == NDIG-1) ? 0 : idx+1.
- Frame boundary is slot_cnt all ones with idx == NDIG-1.
  - On that edge, snap (4*NDIG) captures digits.
  - Digits are shown only from snap, so a frame never shows a torn value.
  - Changing digits mid-frame has no effect until the next frame.
- Outputs are registered with one-clock latency. On every edge:
  - seg_digit <= snap[idx].
  - com <= onehot(idx) when all of the following hold: slot_cnt < brightness, display_on, !hold, !lz(idx). Otherwise com <= 0.
- Leading zero, lz(i):
  - True when blank_lz is set, i > 0, and snap digits i..NDIG-1 are all zero.
  - Digit 0 is never blanked.
  - Values > 9 are passed through unmodified and count as non-zero.
- Brightness:
  - Duty is brightness/2^SLOT_W; maximum is (2^SLOT_W-1)/2^SLOT_W.
  - brightness = 0 forces com = 0 permanently.
  - A brightness change takes effect on the next compare; no synchronisation is needed.
- Timeout counter tmo (TMO_W bits):
  - activity loads all ones; activity has priority over a simultaneous tick.
  - Otherwise tick with tmo != 0 decrements.
  - tmo = 0 holds at 0 (no wrap).
  - display_on is registered as (next tmo != 0), so it changes on the same edge as tmo.
- hold and timeout blanking affect only com. Scanning, snap and seg_digit keep running, so the phase is continuous when the display re-enables.
- Reset mid-frame discards the frame. The first frame after reset shows snap = 0 until the first frame boundary.
- No combinational path from any input to any output.

Test Plan:
- Reset: drive digits = 8'h42 and activity during rst_n low -> after release com = 0, seg_digit = 0, display_on = 0, and tmo stays 0 since reset has priority.
- Scan timing, NDIG=2, SLOT_W=4, brightness = 8, one activity pulse, digits = 8'h37:
  - After the first frame boundary, each 32-clock frame shows com = 01 for 8 clocks with seg_digit = 7.
  - Then com = 00 for 8 clocks.
  - Then com = 10 for 8 clocks with seg_digit = 3.
  - Then com = 00 for 8 clocks.
- Leading zero: digits = 8'h05, blank_lz = 1 -> com[1] never high and com[0] pulses normally. blank_lz = 0 -> com[1] pulses with seg_digit = 0.
- Timeout: activity once, then 255 tick pulses -> display_on falls on the edge of the 255th tick and com stays 0. activity together with a tick -> tmo = 255.
- Snapshot: change digits from 8'h12 to 8'h98 mid-frame -> seg_digit shows 2/1 until the frame boundary, then 8/9.
- Blanking: hold = 1 or brightness = 0 -> com = 0 while seg_digit keeps cycling. Releasing hold resumes com in the current slot phase.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: scan and brightness controller for the multiplexed
// 7-segment display on the dice board.
//
// Time-multiplexes NDIG BCD digits onto one shared segment decoder and
// drives one active-high common enable per digit.  Adds PWM brightness,
// leading-zero blanking, blank-while-held and an inactivity timeout.
//
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   tick       single-cycle timeout pulse (nominally 32 Hz)
//   digits     BCD digits, [3:0] is the least significant digit
//   activity   pulse, reloads the timeout counter
//   hold       level, blanks all commons while high
//   blank_lz   enables leading-zero suppression
//   brightness on-clocks per slot, 0 = dark
//   seg_digit  BCD value for the decoder (registered)
//   com        one-hot-or-zero common enables, active high (registered)
//   display_on timeout counter non-zero (registered)
module seg7_scan_ctrl #(
  parameter int NDIG   = 2,
  parameter int SLOT_W = 4,
  parameter int TMO_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic [4*NDIG-1:0]    digits,
  input  logic                 activity,
  input  logic                 hold,
  input  logic                 blank_lz,
  input  logic [SLOT_W-1:0]    brightness,
  output logic [3:0]           seg_digit,
  output logic [NDIG-1:0]      com,
  output logic                 display_on
);

  localparam int IDX_W = (NDIG > 2) ? 2 : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NDIG - 1);

  logic [SLOT_W-1:0] slot_cnt;
  logic [IDX_W-1:0]  idx;
  logic [4*NDIG-1:0] snap;
  logic [TMO_W-1:0]  tmo;

  logic              slot_end;
  logic              frame_end;
  logic              lz;
  logic              com_en;
  logic [3:0]        cur_digit;
  logic [NDIG-1:0]   com_nxt;
  logic [TMO_W-1:0]  tmo_nxt;
  int unsigned       idx_u;

  always_comb begin
    slot_end  = &slot_cnt;
    frame_end = slot_end && (idx == LAST);
    idx_u     = 32'(idx);
  end

  // Digit select and leading-zero test both work on the frame snapshot,
  // so blanking never flickers when the live digits change mid-frame.
  always_comb begin
    cur_digit = '0;
    lz        = blank_lz && (idx != '0);
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (i == idx_u)
        cur_digit = snap[4*i +: 4];
      if (i >= idx_u && snap[4*i +: 4] != 4'd0)
        lz = 1'b0;
    end
  end

  always_comb begin
    com_en = (slot_cnt < brightness) && display_on && !hold && !lz;
    for (int unsigned i = 0; i < NDIG; i++)
      com_nxt[i] = com_en && (i == idx_u);
  end

  // Activity wins over a simultaneous tick; the counter saturates at zero.
  always_comb begin
    tmo_nxt = tmo;
    if (activity)
      tmo_nxt = '1;
    else if (tick && tmo != '0)
      tmo_nxt = tmo - TMO_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_cnt   <= '0;
      idx        <= '0;
      snap       <= '0;
      tmo        <= '0;
      seg_digit  <= '0;
      com        <= '0;
      display_on <= 1'b0;
    end else begin
      slot_cnt <= slot_cnt + SLOT_W'(1);
      if (slot_end)
        idx <= (idx == LAST) ? '0 : idx + IDX_W'(1);
      if (frame_end)
        snap <= digits;
      tmo        <= tmo_nxt;
      display_on <= (tmo_nxt != '0);
      seg_digit  <= cur_digit;
      com        <= com_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Testbench for seg7_scan_ctrl: directed phases from the test plan followed
// by a randomized phase, every cycle compared against a time-based model.
module tb_seg7_scan_ctrl;

  localparam int NDIG   = 2;
  localparam int SLOT_W = 4;
  localparam int TMO_W  = 8;
  localparam int SLOT   = 1 << SLOT_W;
  localparam int FRAME  = SLOT * NDIG;
  localparam int TMO_MAX = (1 << TMO_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              tick;
  logic [4*NDIG-1:0] digits;
  logic              activity;
  logic              hold;
  logic              blank_lz;
  logic [SLOT_W-1:0] brightness;
  logic [3:0]        seg_digit;
  logic [NDIG-1:0]   com;
  logic              display_on;

  seg7_scan_ctrl #(.NDIG(NDIG), .SLOT_W(SLOT_W), .TMO_W(TMO_W)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .digits(digits),
    .activity(activity), .hold(hold), .blank_lz(blank_lz),
    .brightness(brightness), .seg_digit(seg_digit), .com(com),
    .display_on(display_on)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: position in time since reset determines which digit is shown.
  int m_t = 0;
  int m_tmo = 0;
  int m_snap[NDIG];
  int exp_seg = 0;
  int exp_com = 0;
  int exp_don = 0;
  int com_seen1 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    int pos, di, slot;
    bit lz;
    if (!rst_n) begin
      m_t = 0; m_tmo = 0; exp_seg = 0; exp_com = 0; exp_don = 0;
      for (int i = 0; i < NDIG; i++) m_snap[i] = 0;
      return;
    end
    pos  = m_t % FRAME;
    di   = pos / SLOT;
    slot = pos % SLOT;
    exp_seg = m_snap[di];
    lz = blank_lz && di > 0;
    for (int i = di; i < NDIG; i++) if (m_snap[i] != 0) lz = 0;
    exp_com = (slot < int'(brightness) && m_tmo != 0 && !hold && !lz) ? (1 << di) : 0;
    if (pos == FRAME - 1)
      for (int i = 0; i < NDIG; i++) m_snap[i] = int'(digits[4*i +: 4]);
    if (activity) m_tmo = TMO_MAX;
    else if (tick && m_tmo > 0) m_tmo = m_tmo - 1;
    exp_don = (m_tmo != 0) ? 1 : 0;
    m_t++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("seg_digit", 32'(seg_digit), 32'(exp_seg));
    check("com", 32'(com), 32'(exp_com));
    check("display_on", 32'(display_on), 32'(exp_don));
    if (com[1]) com_seen1++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; digits = 8'h42; activity = 1'b1;
    hold = 1'b0; blank_lz = 1'b0; brightness = '0;
    // Reset has priority over activity.
    run(3);
    rst_n = 1'b1; activity = 1'b0;
    step();
    check("reset_display_on", 32'(display_on), 32'd0);
    check("reset_com", 32'(com), 32'd0);

    // Scan timing with digits 0x37, brightness 8.
    brightness = 4'd8; digits = 8'h37; activity = 1'b1;
    step();
    activity = 1'b0;
    run(4 * FRAME);

    // Leading zero suppression.
    digits = 8'h05; blank_lz = 1'b1;
    run(2 * FRAME);
    com_seen1 = 0;
    run(2 * FRAME);
    check("lz_com1_never", 32'(com_seen1), 32'd0);
    blank_lz = 1'b0;
    run(FRAME);
    com_seen1 = 0;
    run(FRAME);
    check("nolz_com1_pulses", 32'(com_seen1), 32'd8);

    // Snapshot: change digits mid-frame.
    digits = 8'h12;
    run(2 * FRAME + 10);
    digits = 8'h98;
    run(2 * FRAME);

    // Blanking by hold and by zero brightness; release in mid-slot.
    brightness = 4'd15;
    hold = 1'b1;
    run(FRAME + 5);
    hold = 1'b0;
    run(FRAME);
    brightness = 4'd0;
    run(2 * FRAME);
    brightness = 4'd15;
    run(FRAME);

    // Timeout: one activity then TMO_MAX ticks, then activity with tick.
    activity = 1'b1; step(); activity = 1'b0;
    for (int i = 0; i < TMO_MAX; i++) begin
      tick = 1'b1; step();
      tick = 1'b0; step();
    end
    check("timeout_display_off", 32'(display_on), 32'd0);
    run(FRAME);
    activity = 1'b1; tick = 1'b1; step();
    activity = 1'b0; tick = 1'b0;
    check("act_tick_display_on", 32'(display_on), 32'd1);
    check("act_tick_tmo", 32'(dut.tmo), 32'(TMO_MAX));
    run(FRAME);

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 40) == 0) digits = 8'($urandom);
      if ($urandom_range(0, 100) == 0) brightness = SLOT_W'($urandom);
      if ($urandom_range(0, 60) == 0) hold = ~hold;
      if ($urandom_range(0, 80) == 0) blank_lz = ~blank_lz;
      tick = ($urandom_range(0, 3) == 0);
      activity = ($urandom_range(0, 400) == 0);
      rst_n = ($urandom_range(0, 1500) != 0);
      step();
    end
    rst_n = 1'b1;
    run(FRAME);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
